// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths, reset address, FIFO sizing and fetch FSM encoding
package inst_fetch_unit_pkg;
  localparam int WORD = 32;
  localparam logic [WORD-1:0] START_ADRS = 32'h0000_0000;
  localparam int HCYCL = 5;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR_W = 2;
  localparam logic [1:0] INST_ALIGN = 2'b00;
  typedef enum logic [1:0] {FS_RESET = 2'd0, FS_FETCH = 2'd1, FS_FULL = 2'd2} fs_e;
endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// inst_fetch_unit_fifo: synchronous {pc,inst} prefetch FIFO with push/pop/clear and occupancy out
module inst_fetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic [PTR_W:0] count
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & (cnt_q != FULL);
    do_pop = pop & (cnt_q != '0);
    dout = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_q <= do_pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_q <= cnt_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end
  // Storage needs no reset: entries are only observed once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, 1-cycle ROM issue, prefetch FIFO, redirect flush.
// Define FETCH_PERF_EN to add the perf_fetched/perf_flushed counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = FQ_PTR_W
) (
  input  logic            clk_cpu,
  input  logic            reset,
  output logic            mem_req,
  output logic [WORD-1:0] mem_adrs,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [WORD-1:0] inst,
  output logic [WORD-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);
  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WORD-1:0] ALIGN_MASK = {{(WORD - 2){1'b1}}, INST_ALIGN};
  fs_e state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d, rd_pc_q;
  logic inflight_q;
  logic push, pop;
  logic [CW-1:0] count, occ, cnt_nxt;
  logic [2*WORD-1:0] head;
  inst_fetch_unit_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(2 * WORD)) u_fifo (
    .clk(clk_cpu),
    .rst(reset),
    .clr(redirect),
    .push(push),
    .pop(pop),
    .din({rd_pc_q, mem_rdata}),
    .dout(head),
    .count(count)
  );
  // A popped slot is not credited until the next cycle, so occupancy uses the current count.
  always_comb begin
    inst_valid = count != '0;
    pop = inst_valid & inst_ready;
    push = inflight_q & ~redirect;
    occ = count + CW'(inflight_q);
    mem_req = (state_q == FS_FETCH) && (occ < FULL) && !redirect;
    mem_adrs = pc_q;
    cnt_nxt = redirect ? '0 : count + CW'(push) - CW'(pop);
    state_d = (state_q == FS_RESET || redirect) ? FS_FETCH :
              (cnt_nxt + CW'(mem_req) == FULL) ? FS_FULL : FS_FETCH;
    pc_d = redirect ? (redirect_pc & ALIGN_MASK) : mem_req ? pc_q + 32'd4 : pc_q;
    inst = inst_valid ? head[WORD-1:0] : '0;
    inst_pc = inst_valid ? head[2*WORD-1:WORD] : '0;
  end
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q <= FS_RESET;
      pc_q <= START_ADRS;
      rd_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rd_pc_q <= mem_req ? pc_q : rd_pc_q;
      inflight_q <= mem_req;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      if (redirect) perf_flushed <= perf_flushed + 32'(count) - 32'(pop) + 32'(inflight_q);
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of issue, latency, back-pressure, redirect and reset
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;
  logic clk_cpu = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0;
  logic inst_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] rd_adr = '0;
  logic mem_req, inst_valid;
  logic [31:0] mem_adrs, mem_rdata, inst, inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  int checks = 0;
  int errors = 0;
  inst_fetch_unit dut (
    .clk_cpu(clk_cpu),
    .reset(reset),
    .mem_req(mem_req),
    .mem_adrs(mem_adrs),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );
  always #HCYCL clk_cpu = ~clk_cpu;
  // ROM holds its word index at every address, read with one cycle of latency.
  always @(posedge clk_cpu) rd_adr <= mem_adrs;
  assign mem_rdata = rd_adr >> 2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask
  task automatic stream(input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      pc = pc0 + 32'(4 * i);
      chk("stream_valid", {31'b0, inst_valid}, 32'd1);
      chk("stream_pc", inst_pc, pc);
      chk("stream_inst", inst, pc >> 2);
    end
  endtask
  initial begin
    repeat (5) tick();
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_req0", {31'b0, mem_req}, 32'd0);
    tick();
    chk("rel_req1", {31'b0, mem_req}, 32'd1);
    chk("rel_adrs1", mem_adrs, START_ADRS);
    tick();
    chk("rel_adrs2", mem_adrs, START_ADRS + 32'd4);
    chk("rel_valid2", {31'b0, inst_valid}, 32'd0);
    tick();
    stream(START_ADRS, 6);
    inst_ready = 1'b0;
    repeat (10) tick();
    chk("full_req", {31'b0, mem_req}, 32'd0);
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_pc", inst_pc, 32'd20);
    chk("full_inst", inst, 32'd5);
    inst_ready = 1'b1;
    stream(32'd20, 8);
    inst_ready = 1'b0;
    tick();
    tick();
    chk("pre_redir_req", {31'b0, mem_req}, 32'd0);
    chk("pre_redir_inst", inst, 32'd12);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0104;
    inst_ready = 1'b1;
    #1;
    chk("redir_req", {31'b0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_valid1", {31'b0, inst_valid}, 32'd0);
    chk("redir_req1", {31'b0, mem_req}, 32'd1);
    chk("redir_adrs1", mem_adrs, 32'h0000_0104);
    tick();
    chk("redir_valid2", {31'b0, inst_valid}, 32'd0);
    tick();
    stream(32'h0000_0104, 3);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0107;
    tick();
    redirect = 1'b0;
    #1;
    chk("unalign_adrs", mem_adrs, 32'h0000_0104);
    tick();
    tick();
    stream(32'h0000_0104, 2);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap_adrs0", mem_adrs, 32'hFFFF_FFFC);
    tick();
    chk("wrap_adrs1", mem_adrs, 32'h0000_0000);
    tick();
    stream(32'hFFFF_FFFC, 3);
    reset = 1'b1;
    tick();
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstwin_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("rstwin_req", {31'b0, mem_req}, 32'd1);
    chk("rstwin_adrs", mem_adrs, START_ADRS);
    tick();
    tick();
    stream(START_ADRS, 2);
`ifdef FETCH_PERF_EN
    reset = 1'b1;
    tick();
    chk("perf_rst_fetched", perf_fetched, 32'd0);
    chk("perf_rst_flushed", perf_flushed, 32'd0);
    reset = 1'b0;
    repeat (11) tick();
    chk("perf_head", inst, 32'd8);
    inst_ready = 1'b0;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    #1;
    chk("perf_fetched", perf_fetched, 32'd8);
    chk("perf_flushed", perf_flushed, 32'd4);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
